// File: rtl/hc_sr04_ranger.sv
// HC-SR04 ultrasonic ranger: periodic trigger, echo width measurement in whole
// centimetres, and serial double-dabble conversion to four packed BCD digits.
module hc_sr04_ranger #(
    parameter int unsigned TRIG_CYC   = 500,
    parameter int unsigned PERIOD_CYC = 3_000_000,
    parameter int unsigned CM_DIV     = 2900,
    parameter int unsigned MAX_CM     = 400,
    parameter int unsigned RISE_TO    = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        echo,
    output logic        trig,
    output logic [15:0] hc_data,
    output logic        data_valid,
    output logic        err
);
    localparam int unsigned PW = $clog2(PERIOD_CYC);
    localparam int unsigned SW = (CM_DIV > 1) ? $clog2(CM_DIV) : 1;
    localparam int unsigned CW = $clog2(MAX_CM + 1);

    localparam logic [PW-1:0] P_LAST = PW'(PERIOD_CYC - 1);
    localparam logic [PW-1:0] T_END  = PW'(TRIG_CYC);
    localparam logic [PW-1:0] R_END  = PW'(TRIG_CYC + RISE_TO);
    localparam logic [SW-1:0] S_LAST = SW'(CM_DIV - 1);
    localparam logic [CW-1:0] C_MAX  = CW'(MAX_CM);
    localparam logic [3:0]    DD_N   = 4'(CW);

    typedef enum logic [2:0] {HOLD, TRIG, WAIT_RISE, MEASURE, CONVERT} state_t;

    state_t        state;
    logic [PW-1:0] cnt_period;
    logic [SW-1:0] sub;
    logic [CW-1:0] cm;
    logic [15:0]   bcd;
    logic [15:0]   bcd_adj;
    logic [3:0]    shift_cnt;
    logic          echo_m, echo_s, echo_d;
    logic          echo_rise, echo_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
            echo_d <= echo_s;
        end
    end

    assign echo_rise = echo_s & ~echo_d;
    assign echo_fall = ~echo_s & echo_d;

    always_ff @(posedge clk) begin
        if (reset || cnt_period == P_LAST)
            cnt_period <= '0;
        else
            cnt_period <= cnt_period + PW'(1);
    end

    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < 4; i++)
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    // Trigger end and rise timeout are both measured against cnt_period,
    // which is known to be 0 on the edge that enters TRIG.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HOLD;
            trig       <= 1'b0;
            hc_data    <= '0;
            data_valid <= 1'b0;
            err        <= 1'b0;
            sub        <= '0;
            cm         <= '0;
            bcd        <= '0;
            shift_cnt  <= '0;
        end else begin
            data_valid <= 1'b0;
            if (cnt_period == '0) begin
                state <= TRIG;
                trig  <= 1'b1;
            end else begin
                case (state)
                    HOLD: trig <= 1'b0;
                    TRIG: begin
                        if (cnt_period == T_END) begin
                            trig  <= 1'b0;
                            state <= WAIT_RISE;
                        end
                    end
                    WAIT_RISE: begin
                        if (echo_rise) begin
                            // the rising-edge cycle is the first counted high cycle
                            sub   <= SW'(1);
                            cm    <= '0;
                            state <= MEASURE;
                        end else if (cnt_period == R_END) begin
                            hc_data    <= 16'h9999;
                            err        <= 1'b1;
                            data_valid <= 1'b1;
                            state      <= HOLD;
                        end
                    end
                    MEASURE: begin
                        if (echo_fall) begin
                            bcd       <= '0;
                            shift_cnt <= '0;
                            state     <= CONVERT;
                        end else if (echo_s) begin
                            if (sub == S_LAST) begin
                                sub <= '0;
                                if (cm == C_MAX) begin
                                    hc_data    <= 16'h9999;
                                    err        <= 1'b1;
                                    data_valid <= 1'b1;
                                    state      <= HOLD;
                                end else begin
                                    cm <= cm + CW'(1);
                                end
                            end else begin
                                sub <= sub + SW'(1);
                            end
                        end
                    end
                    CONVERT: begin
                        if (shift_cnt == DD_N) begin
                            hc_data    <= bcd;
                            err        <= 1'b0;
                            data_valid <= 1'b1;
                            state      <= HOLD;
                        end else begin
                            {bcd, cm} <= {bcd_adj, cm} << 1;
                            shift_cnt <= shift_cnt + 4'd1;
                        end
                    end
                    default: state <= HOLD;
                endcase
            end
        end
    end
endmodule
